branch_resolve_unit: RTL and testbench

- Execute-side counterpart of the fetch-stage branch predictor.
- Carries each fetch prediction (taken bit, predicted target) through F→D→E alongside the instruction.
- At Execute, compares the prediction with the actual outcome, raises redirect, and supplies the restore PC.
- Emits a registered one-cycle update packet that the BTB/PHT consume to train.

---
 rtl/branch_resolve_unit.sv | 149 ++++++++++++++
 tb/tb_branch_resolve_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: carries fetch-stage branch predictions through F->D->E,
// resolves them against the actual outcome at Execute, raises a same-cycle
// redirect with the restore PC, and emits a registered predictor-update packet.
// Optional performance counters are built when BRU_PERF_CNT_EN is defined.
module branch_resolve_unit #(
  parameter int XLEN          = 32,
  parameter int UPD_ALIGN_LSB = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_D,
  input  logic            stall_E,
  input  logic            flush_D,
  input  logic            flush_E,
  input  logic            valid_F,
  input  logic            pred_taken_F,
  input  logic [XLEN-1:0] pred_target_F,
  input  logic [XLEN-1:0] pc_E,
  input  logic [XLEN-1:0] pc4_E,
  input  logic            branch_E,
  input  logic            jump_E,
  input  logic            actual_taken_E,
  input  logic [XLEN-1:0] target_E,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            upd_valid,
  output logic [XLEN-1:0] upd_pc,
  output logic [XLEN-1:0] upd_target,
  output logic            upd_taken,
  output logic            upd_jump,
  output logic            pred_taken_E,
  output logic [31:0]     branch_cnt,
  output logic [31:0]     mispred_cnt
);

  localparam logic [XLEN-1:0] ALIGN_MASK = {XLEN{1'b1}} << UPD_ALIGN_LSB;

  logic            vld_d, taken_d;
  logic [XLEN-1:0] target_d;
  logic            vld_e, taken_e;
  logic [XLEN-1:0] target_e;

  logic            mispredict;
  logic [XLEN-1:0] restore_pc;
  logic            act;
  logic            retire;

  // F->D prediction metadata: a redirect or flush kills it, a stall holds it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_d    <= 1'b0;
      taken_d  <= 1'b0;
      target_d <= '0;
    end else if (redirect || flush_D) begin
      vld_d    <= 1'b0;
      taken_d  <= 1'b0;
    end else if (!stall_D) begin
      vld_d    <= valid_F;
      taken_d  <= pred_taken_F;
      target_d <= pred_target_F;
    end
  end

  // D->E prediction metadata: a redirect kills E even while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_e    <= 1'b0;
      taken_e  <= 1'b0;
      target_e <= '0;
    end else if (redirect || flush_E) begin
      vld_e    <= 1'b0;
      taken_e  <= 1'b0;
    end else if (!stall_E) begin
      vld_e    <= vld_d;
      taken_e  <= taken_d;
      target_e <= target_d;
    end
  end

  // Compare carried prediction with the actual outcome; jump wins over branch
  always_comb begin
    mispredict = 1'b0;
    restore_pc = '0;
    if (jump_E) begin
      mispredict = !taken_e || (target_E != target_e);
      restore_pc = target_E;
    end else if (branch_E) begin
      mispredict = (actual_taken_E != taken_e) ||
                   (actual_taken_E && taken_e && (target_E != target_e));
      restore_pc = actual_taken_E ? target_E : pc4_E;
    end else if (taken_e) begin
      // BTB hit on a non-control-flow instruction: fall through to pc+4
      mispredict = 1'b1;
      restore_pc = pc4_E;
    end else begin
      mispredict = 1'b0;
      restore_pc = '0;
    end
  end

  assign redirect     = vld_e & mispredict;
  assign redirect_pc  = redirect ? restore_pc : '0;
  assign pred_taken_E = vld_e & taken_e;
  assign act          = vld_e & (branch_E | jump_E);
  // An instruction leaves E when it advances or when its own redirect kills it,
  // so a mispredicting branch held by stall_E still trains exactly once.
  assign retire       = act & (!stall_E | redirect);

  // Registered one-cycle update packet; payload holds between pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_valid  <= 1'b0;
      upd_pc     <= '0;
      upd_target <= '0;
      upd_taken  <= 1'b0;
      upd_jump   <= 1'b0;
    end else begin
      upd_valid <= retire;
      if (retire) begin
        upd_pc     <= pc_E & ALIGN_MASK;
        upd_target <= target_E & ALIGN_MASK;
        upd_taken  <= actual_taken_E | jump_E;
        upd_jump   <= jump_E;
      end
    end
  end

`ifdef BRU_PERF_CNT_EN
  logic [31:0] branch_cnt_q, mispred_cnt_q;

  // Free-running wrap-around counters of resolved and mispredicted transfers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_q  <= 32'd0;
      mispred_cnt_q <= 32'd0;
    end else begin
      if (retire)   branch_cnt_q  <= branch_cnt_q + 32'd1;
      if (redirect) mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;
`else
  assign branch_cnt  = 32'd0;
  assign mispred_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_D, stall_E, flush_D, flush_E;
  logic        valid_F, pred_taken_F;
  logic [31:0] pred_target_F, pc_E, pc4_E, target_E;
  logic        branch_E, jump_E, actual_taken_E;
  logic        redirect, upd_valid, upd_taken, upd_jump, pred_taken_E;
  logic [31:0] redirect_pc, upd_pc, upd_target, branch_cnt, mispred_cnt;

  int total = 0;
  int bad   = 0;
  int rcnt, ucnt;

  branch_resolve_unit #(.XLEN(32), .UPD_ALIGN_LSB(2)) dut (
    .clk(clk), .rst_n(rst_n), .stall_D(stall_D), .stall_E(stall_E),
    .flush_D(flush_D), .flush_E(flush_E), .valid_F(valid_F),
    .pred_taken_F(pred_taken_F), .pred_target_F(pred_target_F),
    .pc_E(pc_E), .pc4_E(pc4_E), .branch_E(branch_E), .jump_E(jump_E),
    .actual_taken_E(actual_taken_E), .target_E(target_E),
    .redirect(redirect), .redirect_pc(redirect_pc), .upd_valid(upd_valid),
    .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
    .upd_jump(upd_jump), .pred_taken_E(pred_taken_E),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_e();
    branch_E = 1'b0; jump_E = 1'b0; actual_taken_E = 1'b0;
    pc_E = 32'd0; pc4_E = 32'd0; target_E = 32'd0;
  endtask

  // Send one prediction from F into E (two edges), leaving F idle
  task automatic push(input logic tk, input logic [31:0] tgt);
    valid_F = 1'b1; pred_taken_F = tk; pred_target_F = tgt;
    step();
    valid_F = 1'b0; pred_taken_F = 1'b0; pred_target_F = 32'd0;
    step();
  endtask

  // Full branch transaction: predict, resolve, let it leave E
  task automatic do_br(input logic tk, input logic [31:0] ptgt,
                       input logic at, input logic [31:0] tgt);
    push(tk, ptgt);
    branch_E = 1'b1; actual_taken_E = at; target_E = tgt;
    pc_E = 32'h1000; pc4_E = 32'h1004;
    step();
    clear_e();
  endtask

  initial begin
    rst_n = 1'b0;
    stall_D = 1'b0; stall_E = 1'b0; flush_D = 1'b0; flush_E = 1'b0;
    valid_F = 1'b0; pred_taken_F = 1'b0; pred_target_F = 32'd0;
    clear_e();
    #23;
    chk1 ("rst_redirect", redirect, 1'b0);
    chk1 ("rst_upd_valid", upd_valid, 1'b0);
    chk1 ("rst_pred_taken_E", pred_taken_E, 1'b0);
    chk32("rst_upd_pc", upd_pc, 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk1("post_rst_redirect", redirect, 1'b0);

    // Correctly predicted taken branch
    push(1'b1, 32'h100);
    branch_E = 1'b1; actual_taken_E = 1'b1; target_E = 32'h100;
    pc_E = 32'h10; pc4_E = 32'h14;
    #1;
    chk1 ("ok_tk_redirect", redirect, 1'b0);
    chk32("ok_tk_redirect_pc", redirect_pc, 32'd0);
    chk1 ("ok_tk_pred_taken_E", pred_taken_E, 1'b1);
    step(); clear_e(); #1;
    chk1 ("ok_tk_upd_valid", upd_valid, 1'b1);
    chk32("ok_tk_upd_pc", upd_pc, 32'h10);
    chk32("ok_tk_upd_target", upd_target, 32'h100);
    chk1 ("ok_tk_upd_taken", upd_taken, 1'b1);
    chk1 ("ok_tk_upd_jump", upd_jump, 1'b0);
    step();
    chk1 ("ok_tk_upd_pulse", upd_valid, 1'b0);
    chk32("ok_tk_upd_pc_hold", upd_pc, 32'h10);

    // Predicted not-taken, actually taken; a taken prediction in F must be killed
    push(1'b0, 32'd0);
    branch_E = 1'b1; actual_taken_E = 1'b1; target_E = 32'h80;
    pc_E = 32'h40; pc4_E = 32'h44;
    valid_F = 1'b1; pred_taken_F = 1'b1; pred_target_F = 32'h500;
    #1;
    chk1 ("nt_tk_redirect", redirect, 1'b1);
    chk32("nt_tk_redirect_pc", redirect_pc, 32'h80);
    step(); clear_e();
    valid_F = 1'b0; pred_taken_F = 1'b0; pred_target_F = 32'd0;
    #1;
    chk1 ("nt_tk_upd_valid", upd_valid, 1'b1);
    chk1 ("nt_tk_upd_taken", upd_taken, 1'b1);
    chk32("nt_tk_upd_pc", upd_pc, 32'h40);
    chk1 ("nt_tk_e_killed", pred_taken_E, 1'b0);
    step();
    chk1 ("nt_tk_d_killed_pred", pred_taken_E, 1'b0);
    chk1 ("nt_tk_d_killed_redir", redirect, 1'b0);

    // Predicted taken, actually not taken
    push(1'b1, 32'h20);
    branch_E = 1'b1; actual_taken_E = 1'b0; target_E = 32'h30;
    pc_E = 32'h20; pc4_E = 32'h24;
    #1;
    chk1 ("tk_nt_redirect", redirect, 1'b1);
    chk32("tk_nt_redirect_pc", redirect_pc, 32'h24);
    step(); clear_e(); #1;
    chk1 ("tk_nt_upd_valid", upd_valid, 1'b1);
    chk1 ("tk_nt_upd_taken", upd_taken, 1'b0);
    chk32("tk_nt_upd_target", upd_target, 32'h30);

    // Correctly predicted not-taken branch
    push(1'b0, 32'd0);
    branch_E = 1'b1; actual_taken_E = 1'b0; target_E = 32'h70;
    pc_E = 32'h68; pc4_E = 32'h6c;
    #1;
    chk1("ok_nt_redirect", redirect, 1'b0);
    step(); clear_e(); #1;
    chk1("ok_nt_upd_valid", upd_valid, 1'b1);
    chk1("ok_nt_upd_taken", upd_taken, 1'b0);

    // Jump, right direction, wrong target
    push(1'b1, 32'h200);
    jump_E = 1'b1; target_E = 32'h300; pc_E = 32'h60; pc4_E = 32'h64;
    #1;
    chk1 ("jmp_redirect", redirect, 1'b1);
    chk32("jmp_redirect_pc", redirect_pc, 32'h300);
    step(); clear_e(); #1;
    chk1 ("jmp_upd_valid", upd_valid, 1'b1);
    chk1 ("jmp_upd_jump", upd_jump, 1'b1);
    chk1 ("jmp_upd_taken", upd_taken, 1'b1);
    chk32("jmp_upd_target", upd_target, 32'h300);

    // Correct jump with unaligned PC/target: payload low bits forced to 0
    push(1'b1, 32'h403);
    jump_E = 1'b1; target_E = 32'h403; pc_E = 32'h107; pc4_E = 32'h10b;
    #1;
    chk1("jmp_ok_redirect", redirect, 1'b0);
    step(); clear_e(); #1;
    chk32("align_upd_pc", upd_pc, 32'h104);
    chk32("align_upd_target", upd_target, 32'h400);

    // BTB alias on a non-branch
    push(1'b1, 32'h700);
    pc_E = 32'h84; pc4_E = 32'h88;
    #1;
    chk1 ("alias_redirect", redirect, 1'b1);
    chk32("alias_redirect_pc", redirect_pc, 32'h88);
    step(); clear_e(); #1;
    chk1("alias_no_upd", upd_valid, 1'b0);

    // stall_E held 3 cycles on a mispredicting branch
    push(1'b0, 32'd0);
    branch_E = 1'b1; actual_taken_E = 1'b1; target_E = 32'h90;
    pc_E = 32'h50; pc4_E = 32'h54;
    rcnt = 0; ucnt = 0;
    for (int i = 0; i < 6; i++) begin
      stall_E = (i < 3); stall_D = (i < 3);
      #1;
      if (redirect)  rcnt++;
      if (upd_valid) ucnt++;
      step();
    end
    clear_e();
    chk32("stall_redirect_cycles", rcnt, 32'd1);
    chk32("stall_upd_pulses", ucnt, 32'd1);
    chk32("stall_upd_pc", upd_pc, 32'h50);

    // flush_D together with stall_D clears D
    valid_F = 1'b1; pred_taken_F = 1'b1; pred_target_F = 32'h123;
    step();
    valid_F = 1'b0; pred_taken_F = 1'b0; pred_target_F = 32'd0;
    stall_D = 1'b1; stall_E = 1'b1; flush_D = 1'b1;
    step();
    stall_D = 1'b0; stall_E = 1'b0; flush_D = 1'b0;
    step();
    chk1("flushD_pred_taken_E", pred_taken_E, 1'b0);

    // flush_E bubbles E
    valid_F = 1'b1; pred_taken_F = 1'b1; pred_target_F = 32'h124;
    step();
    valid_F = 1'b0; pred_taken_F = 1'b0; flush_E = 1'b1;
    step();
    flush_E = 1'b0; #1;
    chk1("flushE_pred_taken_E", pred_taken_E, 1'b0);

    // Reset mid-stream with E holding a mispredict
    push(1'b1, 32'h900);
    branch_E = 1'b1; actual_taken_E = 1'b0; target_E = 32'h904;
    pc_E = 32'h900; pc4_E = 32'h904;
    #1;
    chk1("pre_rst_redirect", redirect, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1 ("mid_rst_redirect", redirect, 1'b0);
    chk32("mid_rst_redirect_pc", redirect_pc, 32'd0);
    chk1 ("mid_rst_upd_valid", upd_valid, 1'b0);
    chk32("mid_rst_upd_pc", upd_pc, 32'd0);
    chk32("mid_rst_upd_target", upd_target, 32'd0);
    chk1 ("mid_rst_pred_taken_E", pred_taken_E, 1'b0);
    chk32("mid_rst_branch_cnt", branch_cnt, 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk1("rel_redirect", redirect, 1'b0);
    step();
    chk1("rel_upd_valid", upd_valid, 1'b0);
    clear_e();

    // Performance counters: 5 branches, 2 mispredicted
    do_br(1'b1, 32'h200, 1'b1, 32'h200);
    do_br(1'b0, 32'h0,   1'b1, 32'h300);
    do_br(1'b0, 32'h0,   1'b0, 32'h300);
    do_br(1'b1, 32'h400, 1'b0, 32'h400);
    do_br(1'b1, 32'h500, 1'b1, 32'h500);
    #1;
`ifdef BRU_PERF_CNT_EN
    chk32("perf_branch_cnt", branch_cnt, 32'd5);
    chk32("perf_mispred_cnt", mispred_cnt, 32'd2);
`else
    chk32("perf_branch_cnt_off", branch_cnt, 32'd0);
    chk32("perf_mispred_cnt_off", mispred_cnt, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
